// File: rtl/clear_sequencer.sv
// Purpose: drives NUM_OUT active-low clearb lines low together on any clear source, then releases them one at a time, bit 0 first.
// Latency: sw_clear acts on the edge that samples it; ext_clear_n acts SYNC_STAGES+1 edges after it falls; clear acts at once, with no clock.
// Backpressure: none; requests are levels that hold the sequence in HOLD until they go inactive.
module clear_sequencer #(
    parameter int NUM_OUT     = 4,
    parameter int STRETCH     = 8,
    parameter int GAP         = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               ext_clear_n,
    input  logic               sw_clear,
    output logic [NUM_OUT-1:0] clearb,
    output logic               busy,
    output logic               done,
    output logic [1:0]         cause
);

    // The last bit is released at this edge count, so count never needs to go past it.
    localparam int MAX_CNT = STRETCH + (NUM_OUT - 1) * GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CNT);

    localparam logic [1:0] CAUSE_CLR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [CW-1:0]          cnt_inc;
    logic [SYNC_STAGES-1:0] ext_sync;
    logic                   ext_req;
    logic                   req;
    logic [NUM_OUT-1:0]     rel_mask;

    // The synchroniser resets to the inactive level so clear does not look like an ext request on release.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ext_sync <= '1;
        end else begin
            ext_sync <= {ext_sync[SYNC_STAGES-2:0], ext_clear_n};
        end
    end

    assign ext_req = ~ext_sync[SYNC_STAGES-1];
    assign req     = ext_req | sw_clear;

    // The count saturates at the last release edge so that a long RUN can never wrap it.
    assign cnt_inc = (count == CNT_MAX) ? count : count + 1'b1;

    // A bit is released once the edge count since the last request reaches its own threshold.
    always_comb begin
        rel_mask = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            rel_mask[i] = (int'(cnt_inc) >= STRETCH + i * GAP);
        end
    end

    // Sequencer: all outputs are registered, so clearb comes straight from flops.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= ST_HOLD;
            count  <= '0;
            clearb <= '0;
            busy   <= 1'b1;
            done   <= 1'b0;
            cause  <= CAUSE_CLR;
        end else begin
            done <= 1'b0;
            if (req) begin
                // A request in any state restarts the stretch; ext has priority for cause.
                state  <= ST_HOLD;
                count  <= '0;
                clearb <= '0;
                busy   <= 1'b1;
                cause  <= ext_req ? CAUSE_EXT : CAUSE_SW;
            end else begin
                case (state)
                    ST_HOLD, ST_REL: begin
                        count  <= cnt_inc;
                        clearb <= rel_mask;
                        if (&rel_mask) begin
                            state <= ST_RUN;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (rel_mask[0]) begin
                            state <= ST_REL;
                        end
                    end
                    ST_RUN: begin
                        clearb <= '1;
                        busy   <= 1'b0;
                    end
                    default: begin
                        state  <= ST_HOLD;
                        count  <= '0;
                        clearb <= '0;
                        busy   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
